// File: rtl/mux_pkg.sv
// Shared constants and helpers for the channel mux / scan family.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Never returns 0, so a degenerate N still yields a usable select width.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Output handshake bundle of mux_scan_n: registered sample, channel tag, valid/ready.
interface mux_scan_n_if #(
    parameter int W  = 8,
    parameter int SW = 3
);
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready;

    modport master (output out_data, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/rr_pick_n.sv
// Combinational round-robin pick: first set mask bit at or after start, wrapping at N-1.
// Zero latency; no handshake.
module rr_pick_n #(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [N-1:0]  mask,
    input  logic [SW-1:0] start,
    output logic [SW-1:0] idx,
    output logic          found
);

    logic [N-1:0]  rot;
    logic [SW-1:0] off;
    logic [SW:0]   sum;

    always_comb begin
        // Rotate so that bit 0 of rot corresponds to channel 'start'.
        rot = N'({mask, mask} >> start);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = SW'(i);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (SW + 1)'(N)) sum = sum - (SW + 1)'(N);
        idx   = sum[SW-1:0];
        found = |mask;
    end

endmodule

// File: rtl/mux_scan_n.sv
// N:1 W-bit channel mux, manual select or round-robin auto-scan over enabled channels.
// One cycle latency from inputs to registered outputs; outputs hold while out_valid && !out_ready.
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  din,
    input  logic [N-1:0]    en_mask,
    mux_scan_n_if.master    out_if
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [SW-1:0] pick_idx;
    logic          pick_found;
    logic          load;
    logic [SW:0]   pick_nxt;

    rr_pick_n #(.N(N), .SW(SW)) u_pick (
        .mask  (en_mask),
        .start (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign load = !out_valid_q || out_if.out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        pick_nxt    = {1'b0, pick_idx} + (SW + 1)'(1);
        if (load) begin
            if (mode == MODE_MANUAL) begin
                // sel can exceed N-1 only when N is not a power of two.
                if ({1'b0, sel} < (SW + 1)'(N)) begin
                    out_data_d  = din[int'(sel)*W +: W];
                    out_ch_d    = sel;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (pick_found) begin
                out_data_d  = din[int'(pick_idx)*W +: W];
                out_ch_d    = pick_idx;
                out_valid_d = 1'b1;
                ptr_d       = (pick_nxt == (SW + 1)'(N)) ? '0 : pick_nxt[SW-1:0];
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_ch    = out_ch_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: an 8x8 instance and a 5-channel 12-bit instance.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        mode8 = 1'b0;
    logic [2:0]  sel8 = '0;
    logic [63:0] din8 = '0;
    logic [7:0]  mask8 = '0;

    logic        mode5 = 1'b0;
    logic [2:0]  sel5 = '0;
    logic [59:0] din5 = '0;
    logic [4:0]  mask5 = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          dut;
        logic        vld;
        logic [5:0]  ch;
        logic [11:0] dat;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mux_scan_n_if #(.W(8), .SW(3))  if8 ();
    mux_scan_n_if #(.W(12), .SW(3)) if5 ();

    mux_scan_n #(.N(8), .W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8),
        .din(din8), .en_mask(mask8), .out_if(if8)
    );

    mux_scan_n #(.N(5), .W(12)) u5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5),
        .din(din5), .en_mask(mask5), .out_if(if5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_din8(input logic [7:0] base);
        for (int k = 0; k < 8; k++) din8[k*8 +: 8] = base + 8'(k);
    endtask

    // Push the expectation, advance one edge, then pop and compare.
    task automatic step(input int dut, input logic vld, input logic [5:0] ch,
                        input logic [11:0] dat, input string tag);
        exp_t e;
        e.dut = dut; e.vld = vld; e.ch = ch; e.dat = dat; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.dut == 8) begin
            chk({e.tag, ".vld"}, 32'(if8.out_valid), 32'(e.vld));
            chk({e.tag, ".ch"},  32'(if8.out_ch),    32'(e.ch));
            chk({e.tag, ".dat"}, 32'(if8.out_data),  32'(e.dat));
        end else begin
            chk({e.tag, ".vld"}, 32'(if5.out_valid), 32'(e.vld));
            chk({e.tag, ".ch"},  32'(if5.out_ch),    32'(e.ch));
            chk({e.tag, ".dat"}, 32'(if5.out_data),  32'(e.dat));
        end
    endtask

    initial begin
        if8.out_ready = 1'b0;
        if5.out_ready = 1'b0;
        set_din8(8'h10);
        for (int k = 0; k < 5; k++) din5[k*12 +: 12] = 12'h100 + 12'(k);

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk("rst.vld8", 32'(if8.out_valid), 32'd0);
        chk("rst.ch8",  32'(if8.out_ch),    32'd0);
        chk("rst.dat8", 32'(if8.out_data),  32'd0);
        chk("rst.vld5", 32'(if5.out_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Manual select, then asynchronous reset mid-cycle
        mode8 = 1'b0; sel8 = 3'd3; if8.out_ready = 1'b1;
        step(8, 1'b1, 6'd3, 12'h013, "man_sel3");
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.vld", 32'(if8.out_valid), 32'd0);
        chk("async_rst.dat", 32'(if8.out_data),  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Full scan with wrap
        mode8 = 1'b1; mask8 = 8'hFF;
        for (int i = 0; i < 10; i++)
            step(8, 1'b1, 6'(i % 8), 12'h010 + 12'(i % 8), "scan_all");

        // Sparse mask, then empty mask, then restore
        mask8 = 8'b1010_0100;
        step(8, 1'b1, 6'd2, 12'h012, "sparse0");
        step(8, 1'b1, 6'd5, 12'h015, "sparse1");
        step(8, 1'b1, 6'd7, 12'h017, "sparse2");
        step(8, 1'b1, 6'd2, 12'h012, "sparse3");
        step(8, 1'b1, 6'd5, 12'h015, "sparse4");
        mask8 = 8'h00;
        step(8, 1'b0, 6'd5, 12'h015, "mask_zero");
        mask8 = 8'b1010_0100;
        step(8, 1'b1, 6'd7, 12'h017, "resume0");
        step(8, 1'b1, 6'd2, 12'h012, "resume1");

        // Backpressure: held sample survives din and mask changes
        mask8 = 8'hFF;
        step(8, 1'b1, 6'd3, 12'h013, "bp_first");
        if8.out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            set_din8(8'h20 + 8'(j * 16));
            mask8 = (j == 2) ? 8'h01 : 8'hFF;
            step(8, 1'b1, 6'd3, 12'h013, "bp_hold");
        end
        mask8 = 8'hFF;
        set_din8(8'h70);
        if8.out_ready = 1'b1;
        step(8, 1'b1, 6'd4, 12'h074, "bp_release");
        set_din8(8'h10);

        // Single enabled channel repeats
        mask8 = 8'b0001_0000;
        step(8, 1'b1, 6'd4, 12'h014, "single0");
        step(8, 1'b1, 6'd4, 12'h014, "single1");

        // Mode switch keeps the scan pointer
        mask8 = 8'hFF;
        for (int i = 5; i < 11; i++)
            step(8, 1'b1, 6'(i % 8), 12'h010 + 12'(i % 8), "pre_switch");
        mode8 = 1'b0; sel8 = 3'd6;
        step(8, 1'b1, 6'd6, 12'h016, "switch_manual");
        mode8 = 1'b1;
        step(8, 1'b1, 6'd3, 12'h013, "switch_back");

        // N=5, W=12: out-of-range select and scan wrap at N-1
        if5.out_ready = 1'b1;
        mode5 = 1'b0; sel5 = 3'd2;
        step(5, 1'b1, 6'd2, 12'h102, "n5_sel2");
        sel5 = 3'd6;
        step(5, 1'b0, 6'd2, 12'h102, "n5_sel6");
        sel5 = 3'd5;
        step(5, 1'b0, 6'd2, 12'h102, "n5_sel5");
        sel5 = 3'd4;
        step(5, 1'b1, 6'd4, 12'h104, "n5_sel4");
        mode5 = 1'b1; mask5 = 5'b10001;
        step(5, 1'b1, 6'd0, 12'h100, "n5_scan0");
        step(5, 1'b1, 6'd4, 12'h104, "n5_scan1");
        step(5, 1'b1, 6'd0, 12'h100, "n5_scan2");

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised N:1, W-bit channel multiplexer with a registered output and a valid/ready output handshake.
- Two modes: manual select, and auto-scan. Auto-scan steps round-robin through enabled channels, one channel per accepted transfer.
- Sits between banks of parallel sources (sensor/ADC lanes, register banks) and a single serial consumer.

Parameters:
- N, 8, number of input channels (2..64)
- W, 8, data width per channel
- SW, $clog2(N), select/pointer width (derived; not to be overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = manual select, 1 = auto-scan
- sel  input  SW  manual channel select
- din  input  N*W  packed channel data; channel k = din[k*W +: W]
- en_mask  input  N  scan enable per channel; bit k=1 includes channel k in scan
- out_data  output  W  registered selected data
- out_ch  output  SW  channel index of out_data
- out_valid  output  1  out_data/out_ch hold a valid sample
- out_ready  input  1  consumer accepts when out_valid && out_ready

Behaviour:
- Reset (async assert, sync deassert by the system): out_data=0, out_ch=0, out_valid=0, scan pointer ptr=0.
- Load condition: load = !out_valid || out_ready. Outside load, all output registers hold. out_data is stable while out_valid && !out_ready.
- Latency: input sampled on a load edge appears on the outputs the same edge, i.e. 1 cycle after being presented.
- Manual mode (mode=0), on load:
  - sel < N: out_data=din[sel], out_ch=sel, out_valid=1.
  - sel >= N (illegal when N is not a power of 2): out_valid=0; out_data and out_ch hold.
  - en_mask is ignored; ptr is unchanged.
- Scan mode (mode=1), on load:
  - Channel c is the first enabled channel at or after ptr, searching upward with wrap from N-1 to 0.
  - out_data=din[c], out_ch=c, out_valid=1, ptr=(c+1) mod N.
  - en_mask==0: out_valid=0, ptr holds.
- Priority search is combinational over N bits: a rotate-and-priority-encode, not an iterative FSM.
- A single enabled channel is output on every load (repeat sampling).
- Mode change takes effect at the next load edge. A held sample is never altered mid-stall.
- en_mask changes during a stall do not affect the held sample; they apply at the next load.
- ptr persists across mode switches. Returning to scan resumes from the stored ptr.
- Reset mid-transfer: out_valid drops immediately (async); the in-flight sample is lost.
- No combinational path from out_ready to any output.

Decomposition:
- Shared package mux_pkg: MODE_MANUAL=1'b0, MODE_SCAN=1'b1; function clog2_min1 (returns >=1 for N=1 safety).
- One natural sub-module: rr_pick_n. Inputs: mask[N], start[SW]. Outputs: idx[SW], found. Combinational rotate-and-priority-encode, reusable by future arbiters.
- The top holds the output register, ptr, and mode logic.

Test Plan:
1. Reset, then manual sel=3, din channel k = 8'h10+k, out_ready=1 -> one cycle later out_data=8'h13, out_ch=3, out_valid=1. Assert rst_n=0 mid-cycle -> out_valid=0 immediately.
2. Scan, en_mask=8'hFF, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1 with matching out_data; ptr wraps.
3. Scan, en_mask=8'b1010_0100 -> out_ch sequence 2,5,7,2,5. Then en_mask=0 -> out_valid=0 and ptr holds. Restore mask -> sequence resumes at the next enabled channel after the held ptr.
4. Backpressure: scan, out_ready=0 for 5 cycles while din changes -> out_data/out_ch frozen at the first sample, ptr does not advance. Then out_ready=1 -> the next channel follows.
5. Parameter sweep N=5, W=12: manual sel=6 -> out_valid=0 and data held. sel=4 -> out_ch=4.
6. Mode switch mid-scan: after out_ch=2, mode=0 with sel=6 -> out_ch=6. Back to mode=1 -> out_ch=3, since ptr is preserved.
